// File: rtl/crc32_frame_ctrl_if.sv
// Byte-stream handshake between the MAC datapath and the CRC frame controller.
// The controller uses the slave view; whoever drives and consumes the streams uses master.
interface crc32_frame_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/crc32_frame_ctrl.sv
// Frame sequencer for one 8-bit parallel CRC-32 engine: TX appends the FCS,
// RX checks the engine remainder and reports frame status.
module crc32_frame_ctrl #(
    parameter int unsigned MAX_LEN    = 1518,
    parameter int unsigned MIN_RX_LEN = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     tx_mode,
    input  logic                     abort,
    crc32_frame_ctrl_if.slave        strm,
    output logic                     crc_clken,
    output logic                     crc_reset,
    output logic                     crc_load,
    output logic                     crc_compute,
    output logic [7:0]               crc_data,
    input  logic [7:0]               crc_data_out,
    input  logic                     crc_ok,
    output logic                     busy,
    output logic                     done,
    output logic                     frame_ok,
    output logic                     frame_err,
    output logic [15:0]              frame_len
);

    typedef enum logic [2:0] {IDLE, INIT, DATA, FCS, CHECK} state_t;

    state_t     state, state_next;
    logic       tx_r;
    logic [1:0] fcs_cnt;
    logic       xfer;
    logic       overflow;
    logic       aborting;

    assign busy     = (state != IDLE);
    assign xfer     = strm.in_valid && strm.out_ready;
    assign overflow = (frame_len >= 16'(MAX_LEN));
    assign aborting = abort && (state == INIT || state == DATA || state == FCS);

    always_comb begin
        state_next     = state;
        strm.in_ready  = 1'b0;
        strm.out_valid = 1'b0;
        strm.out_data  = '0;
        strm.out_last  = 1'b0;
        crc_clken      = 1'b0;
        crc_reset      = 1'b0;
        crc_load       = 1'b0;
        crc_compute    = 1'b0;
        crc_data       = '0;
        if (reset || aborting) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start && !abort) state_next = INIT;
                INIT: begin
                    crc_clken  = 1'b1;
                    crc_reset  = 1'b1;
                    state_next = DATA;
                end
                DATA: begin
                    // Once the count is at the limit the next byte is refused, not forwarded.
                    if (!overflow) begin
                        strm.out_valid = strm.in_valid;
                        strm.out_data  = strm.in_data;
                        strm.in_ready  = strm.out_ready;
                        strm.out_last  = strm.in_last && !tx_r;
                        if (xfer) begin
                            crc_clken   = 1'b1;
                            crc_compute = 1'b1;
                            crc_data    = strm.in_data;
                            if (strm.in_last) state_next = tx_r ? FCS : CHECK;
                        end
                    end else if (xfer) begin
                        state_next = IDLE;
                    end
                end
                FCS: begin
                    strm.out_valid = 1'b1;
                    strm.out_data  = crc_data_out;
                    strm.out_last  = (fcs_cnt == 2'd3);
                    if (strm.out_ready) begin
                        crc_clken = 1'b1;
                        crc_load  = 1'b1;
                        if (fcs_cnt == 2'd3) state_next = IDLE;
                    end
                end
                CHECK:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_r      <= 1'b0;
            fcs_cnt   <= '0;
            done      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            frame_len <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (aborting) begin
                done      <= 1'b1;
                frame_ok  <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        tx_r      <= tx_mode;
                        frame_len <= '0;
                        frame_ok  <= 1'b0;
                        frame_err <= 1'b0;
                    end
                    DATA: if (xfer) begin
                        if (overflow) begin
                            frame_err <= 1'b1;
                            frame_ok  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            if (frame_len != '1) frame_len <= frame_len + 16'd1;
                            if (strm.in_last) fcs_cnt <= '0;
                        end
                    end
                    FCS: if (strm.out_ready) begin
                        fcs_cnt <= fcs_cnt + 2'd1;
                        if (fcs_cnt == 2'd3) begin
                            done     <= 1'b1;
                            frame_ok <= 1'b1;
                        end
                    end
                    CHECK: begin
                        done     <= 1'b1;
                        frame_ok <= crc_ok && (frame_len >= 16'(MIN_RX_LEN));
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Bench for crc32_frame_ctrl with a CRC-32 engine model attached; frames are
// checked against a frame-level reference computed from whole byte queues.
module tb_crc32_frame_ctrl;

    localparam int MAX_LEN    = 8;
    localparam int MIN_RX_LEN = 5;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        bit         tx;
        int         n;
        logic [7:0] base;
        bit         ok;
        bit         err;
        int         len;
        int         nout;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, start, tx_mode, abort;
    logic        crc_clken, crc_reset, crc_load, crc_compute;
    logic [7:0]  crc_data, crc_data_out;
    logic        crc_ok;
    logic        busy, done, frame_ok, frame_err;
    logic [15:0] frame_len;
    logic [31:0] eng;

    int errors = 0;
    int checks = 0;

    bq_t        got_q, exp_q, tx_ref;
    int         last_cnt, last_pos, n_comp, n_load;
    logic       r_ok, r_err;
    logic [15:0] r_len;
    bit         e_ok, e_err;
    int         e_len, e_last;

    crc32_frame_ctrl_if strm();

    crc32_frame_ctrl #(.MAX_LEN(MAX_LEN), .MIN_RX_LEN(MIN_RX_LEN)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_mode(tx_mode), .abort(abort),
        .strm(strm),
        .crc_clken(crc_clken), .crc_reset(crc_reset), .crc_load(crc_load),
        .crc_compute(crc_compute), .crc_data(crc_data),
        .crc_data_out(crc_data_out), .crc_ok(crc_ok),
        .busy(busy), .done(done), .frame_ok(frame_ok), .frame_err(frame_err),
        .frame_len(frame_len)
    );

    always #5 clk = ~clk;

    // MSB-first CRC-32 byte update, polynomial 0x04C11DB7
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            logic fb;
            fb = r[31] ^ d[b];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return r;
    endfunction

    // engine attached to the controller
    always @(posedge clk) begin
        if (reset) eng <= '0;
        else if (crc_clken) begin
            if (crc_reset)        eng <= 32'hFFFF_FFFF;
            else if (crc_compute) eng <= crc_upd(eng, crc_data);
            else if (crc_load)    eng <= {eng[23:0], crc_data};
        end
    end
    assign crc_data_out = ~eng[31:24];
    assign crc_ok       = (eng == 32'hC704DD7B);

    function automatic logic [31:0] fcs_of(input bq_t d, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) c = crc_upd(c, d[i]);
        return ~c;
    endfunction

    function automatic void model(input bit tx, input bq_t d);
        int n;
        n = d.size();
        exp_q = {};
        if (n > MAX_LEN) begin
            for (int i = 0; i < MAX_LEN; i++) exp_q.push_back(d[i]);
            e_ok = 0; e_err = 1; e_len = MAX_LEN; e_last = -1;
        end else if (tx) begin
            logic [31:0] f;
            f = fcs_of(d, n);
            exp_q = d;
            exp_q.push_back(f[31:24]); exp_q.push_back(f[23:16]);
            exp_q.push_back(f[15:8]);  exp_q.push_back(f[7:0]);
            e_ok = 1; e_err = 0; e_len = n; e_last = n + 4;
        end else begin
            exp_q = d;
            e_err = 0; e_len = n; e_last = n; e_ok = 0;
            if (n >= MIN_RX_LEN) begin
                if (fcs_of(d, n - 4) == {d[n-4], d[n-3], d[n-2], d[n-1]}) e_ok = 1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_frame(input bit tx, input bq_t d, input bit stall, input int abort_fcs,
                             input string tag);
        int n;
        int idx;
        bit abort_next, abort_sent, got_done;
        n = d.size();
        idx = 0; abort_next = 0; abort_sent = 0; got_done = 0;
        got_q = {}; last_cnt = 0; last_pos = -1; n_comp = 0; n_load = 0;
        @(negedge clk);
        start = 1; tx_mode = tx; abort = 0;
        strm.in_valid = 0; strm.in_last = 0; strm.out_ready = 1;
        #2 chk({tag, "_idle_before_start"}, {30'd0, done, busy}, 32'd0);
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            @(negedge clk);
            start         = (cyc == 0);
            tx_mode       = 1'($urandom_range(0, 1));
            strm.in_valid = (idx < n) && (!stall || $urandom_range(0, 1) == 1);
            strm.in_data  = (idx < n) ? d[idx] : 8'h00;
            strm.in_last  = (idx == n - 1);
            strm.out_ready = stall ? (cyc % 2 == 1) : 1'b1;
            abort = abort_next;
            abort_next = 0;
            #2;
            if (cyc == 0)
                chk({tag, "_init"}, {25'd0, busy, crc_clken, crc_reset, crc_compute, crc_load,
                    strm.in_ready, strm.out_valid}, {25'd0, 7'b1110000});
            if (abort) chk({tag, "_abort_quiet"}, {30'd0, strm.in_ready, strm.out_valid}, 32'd0);
            if (done) begin
                got_done = 1;
                r_ok = frame_ok; r_err = frame_err; r_len = frame_len;
            end else begin
                if (strm.in_valid && strm.in_ready) idx++;
                if (strm.out_valid && strm.out_ready) begin
                    got_q.push_back(strm.out_data);
                    if (strm.out_last) begin last_cnt++; last_pos = got_q.size(); end
                    if (tx && abort_fcs >= 0 && !abort_sent && got_q.size() == n + abort_fcs) begin
                        abort_next = 1; abort_sent = 1;
                    end
                end
                if (crc_clken && crc_compute) n_comp++;
                if (crc_clken && crc_load)    n_load++;
            end
        end
        start = 0; abort = 0; strm.in_valid = 0; strm.in_last = 0;
        chk({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
    endtask

    task automatic compare_frame(input bit tx, input bq_t d, input int abort_fcs, input string tag);
        int mm;
        model(tx, d);
        if (abort_fcs >= 0) begin
            while (exp_q.size() > d.size() + abort_fcs) void'(exp_q.pop_back());
            e_ok = 0; e_err = 1; e_len = d.size(); e_last = -1;
        end
        chk({tag, "_nout"}, got_q.size(), exp_q.size());
        mm = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mm++;
        chk({tag, "_byte_mismatches"}, mm, 0);
        chk({tag, "_last_count"}, last_cnt, (e_last > 0) ? 1 : 0);
        chk({tag, "_last_pos"}, last_pos, e_last);
        chk({tag, "_frame_ok"}, {31'd0, r_ok}, {31'd0, e_ok});
        chk({tag, "_frame_err"}, {31'd0, r_err}, {31'd0, e_err});
        chk({tag, "_frame_len"}, {16'd0, r_len}, e_len);
    endtask

    vec_t tbl[6];

    initial begin
        bq_t d;
        int  acc;

        tbl[0] = '{1'b1, 4, 8'h01, 1'b1, 1'b0, 4, 8};
        tbl[1] = '{1'b0, 4, 8'h10, 1'b0, 1'b0, 4, 4};
        tbl[2] = '{1'b0, 9, 8'h20, 1'b0, 1'b1, 8, 8};
        tbl[3] = '{1'b1, 9, 8'h30, 1'b0, 1'b1, 8, 8};
        tbl[4] = '{1'b1, 1, 8'hA5, 1'b1, 1'b0, 1, 5};
        tbl[5] = '{1'b1, 8, 8'h40, 1'b1, 1'b0, 8, 12};

        reset = 1; start = 1; tx_mode = 1; abort = 0;
        strm.in_valid = 1; strm.in_data = 8'h55; strm.in_last = 0; strm.out_ready = 1;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_ctrl", {22'd0, busy, done, frame_ok, frame_err, strm.in_ready, strm.out_valid,
            crc_clken, crc_reset, crc_load, crc_compute}, 32'd0);
        chk("reset_len_data", {8'd0, frame_len, crc_data}, 32'd0);
        @(negedge clk);
        reset = 0; start = 0; strm.in_valid = 0;

        // table of directed frames, no backpressure
        for (int k = 0; k < 6; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            d = {};
            for (int i = 0; i < tbl[k].n; i++) d.push_back(tbl[k].base + 8'(i));
            run_frame(tbl[k].tx, d, 1'b0, -1, tag);
            chk({tag, "_tbl_nout"}, got_q.size(), tbl[k].nout);
            chk({tag, "_tbl_status"}, {29'd0, r_ok, r_err, 1'b0}, {29'd0, tbl[k].ok, tbl[k].err, 1'b0});
            chk({tag, "_tbl_len"}, {16'd0, r_len}, tbl[k].len);
            compare_frame(tbl[k].tx, d, -1, tag);
            if (k == 0) tx_ref = got_q;
        end

        // loopback of the 4-byte TX frame, then with one corrupted bit
        run_frame(1'b0, tx_ref, 1'b0, -1, "loop");
        chk("loop_ok", {31'd0, r_ok}, 32'd1);
        chk("loop_len", {16'd0, r_len}, 32'd8);
        compare_frame(1'b0, tx_ref, -1, "loop");
        d = tx_ref;
        d[2] = d[2] ^ 8'h01;
        run_frame(1'b0, d, 1'b0, -1, "loopbad");
        chk("loopbad_status", {30'd0, r_ok, r_err}, 32'd0);
        compare_frame(1'b0, d, -1, "loopbad");

        // backpressure on the same TX payload
        d = {8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(1'b1, d, 1'b1, -1, "stall");
        acc = 0;
        for (int i = 0; i < got_q.size() && i < tx_ref.size(); i++)
            if (got_q[i] !== tx_ref[i]) acc++;
        chk("stall_vs_nostall", acc + (got_q.size() != tx_ref.size()), 0);
        chk("stall_n_compute", n_comp, 4);
        chk("stall_n_load", n_load, 4);

        // abort after two FCS bytes, then a clean frame
        run_frame(1'b1, d, 1'b0, 2, "abort");
        compare_frame(1'b1, d, 2, "abort");
        d = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h11};
        run_frame(1'b1, d, 1'b0, -1, "postabort");
        compare_frame(1'b1, d, -1, "postabort");

        // reset in the middle of DATA
        @(negedge clk);
        start = 1; tx_mode = 1; strm.out_ready = 1; strm.in_valid = 0;
        acc = 0;
        for (int cyc = 0; cyc < 20 && acc < 3; cyc++) begin
            @(negedge clk);
            start = 0;
            strm.in_valid = 1; strm.in_data = 8'(acc + 8'h70); strm.in_last = 0;
            #2;
            if (strm.in_valid && strm.in_ready) acc++;
        end
        chk("rst_bytes_fed", acc, 3);
        @(negedge clk);
        reset = 1; start = 1;
        #2;
        chk("rst_comb_quiet", {25'd0, crc_clken, crc_reset, crc_load, crc_compute,
            strm.in_ready, strm.out_valid, 1'b0}, 32'd0);
        chk("rst_crc_data", {24'd0, crc_data}, 32'd0);
        @(negedge clk);
        #2;
        chk("rst_next_state", {13'd0, busy, done, frame_ok, frame_len}, 32'd0);
        @(negedge clk);
        #2;
        chk("rst_start_ignored", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 0; start = 0; strm.in_valid = 0;
        d = {8'h01, 8'h23, 8'h45};
        run_frame(1'b1, d, 1'b0, -1, "postreset");
        compare_frame(1'b1, d, -1, "postreset");

        // randomized frames against the reference
        for (int f = 0; f < 16; f++) begin
            bit tx;
            bit stall;
            int n;
            string tag;
            tag = $sformatf("rnd%0d", f);
            tx = 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 10);
            d = {};
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            if (!tx && n >= 5 && n <= MAX_LEN && $urandom_range(0, 1) == 1) begin
                logic [31:0] fc;
                fc = fcs_of(d, n - 4);
                d[n-4] = fc[31:24]; d[n-3] = fc[23:16]; d[n-2] = fc[15:8]; d[n-1] = fc[7:0];
            end
            run_frame(tx, d, stall, -1, tag);
            compare_frame(tx, d, -1, tag);
        end

        @(negedge clk);
        #2 chk("final_idle", {30'd0, done, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc32_frame_ctrl.md
Name: crc32_frame_ctrl

Overview:
- Sequences the 8-bit parallel CRC-32 engine (802.3 polynomial) for whole frames.
- TX mode: passes payload bytes through and computes the CRC, then appends the 4-byte FCS by unloading the engine.
- RX mode: passes all bytes (payload plus FCS) through the engine, then reports good/bad from the engine's remainder check.
- Sits between the byte-stream MAC datapath and one CRC engine instance, and owns all of that engine's control inputs.

Parameters:
- MAX_LEN, 1518, maximum bytes accepted per frame, FCS included for RX and excluded for TX; exceeding it is an error.
- MIN_RX_LEN, 5, minimum RX frame length in bytes (FCS included); shorter frames are flagged bad.

Ports:
- clk  in  1  clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- tx_mode  in  1  latched at start: 1 = generate and append FCS, 0 = check.
- abort  in  1  terminate the current frame.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  upstream byte accepted.
- in_data  in  8  upstream byte.
- in_last  in  1  marks the final upstream byte.
- out_valid  out  1  downstream byte valid.
- out_ready  in  1  downstream ready.
- out_data  out  8  downstream byte.
- out_last  out  1  marks the final downstream byte.
- crc_clken  out  1  engine clock enable.
- crc_reset  out  1  engine initialise to 0xFFFFFFFF.
- crc_load  out  1  engine shift-load.
- crc_compute  out  1  engine compute.
- crc_data  out  8  engine data_in.
- crc_data_out  in  8  engine data_out (~crc[31:24]).
- crc_ok  in  1  engine remainder == 0xC704DD7B.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle registered pulse at frame end.
- frame_ok  out  1  frame status, valid while done=1 and held until the next start.
- frame_err  out  1  length error or abort, held like frame_ok.
- frame_len  out  16  data bytes accepted in the last frame, held like frame_ok.

Behaviour:
- States: IDLE, INIT, DATA, FCS, CHECK.
- reset: state goes to IDLE and fcs_cnt to 0. busy, done, frame_ok, frame_err, frame_len, in_ready and out_valid are 0. All crc_* outputs are 0.
- reset and abort outrank every other event.
- Engine signals are combinational from state and handshake. crc_clken is high only in the cycles listed below; in all other cycles the engine holds.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1: latch tx_mode, clear frame_len, frame_ok and frame_err, then go to INIT.
- INIT, exactly one cycle:
  - crc_clken=1, crc_reset=1, so the engine holds 0xFFFFFFFF on entry to DATA.
  - Go to DATA.
- DATA, combinational pass-through:
  - out_valid=in_valid, out_data=in_data, in_ready=out_ready.
  - Transfer condition: in_valid && out_ready. On each transfer: crc_clken=1, crc_compute=1, crc_data=in_data, and frame_len increments (saturating at 0xFFFF).
  - out_last = in_last && !tx_mode; TX suppresses last on payload bytes.
  - Transfer with in_last: TX goes to FCS with fcs_cnt=0; RX goes to CHECK.
  - Transfer that would make frame_len > MAX_LEN: set frame_err, stop accepting (in_ready=0), pulse done with frame_ok=0, and go to IDLE. The offending byte is not forwarded.
- FCS (TX only):
  - in_ready=0, out_valid=1, out_data=crc_data_out, out_last=(fcs_cnt==3).
  - On out_ready: crc_clken=1, crc_load=1, crc_data=8'h00, fcs_cnt increments.
  - Acceptance with fcs_cnt==3: pulse done with frame_ok=1 and go to IDLE.
  - Bytes leave MSB-first, already complemented by the engine.
- CHECK (RX), one cycle:
  - Engine state reflects the last byte.
  - frame_ok = crc_ok && (frame_len >= MIN_RX_LEN).
  - Pulse done and go to IDLE.
- abort in INIT, DATA or FCS: next cycle is IDLE, done=1, frame_ok=0, frame_err=1. No byte is transferred in the abort cycle (in_ready=0, out_valid=0).
- start outside IDLE is ignored.
- in_last on a non-transfer cycle has no effect.
- in_valid held without out_ready: no engine update and no count.
- Back-to-back frames: start may be asserted in the cycle after done. There is a minimum of one IDLE cycle between frames.

Test Plan:
- TX 4-byte frame 0x01,0x02,0x03,0x04 with out_ready=1 -> INIT for 1 cycle, 8 output bytes, out_last only on byte 8, done 1 cycle later, frame_ok=1, frame_len=4.
- Loopback: capture the 8 TX output bytes and replay them as an RX frame -> crc_ok high in CHECK, frame_ok=1, frame_len=8. Flip bit 0 of byte 2 and replay -> frame_ok=0, frame_err=0.
- Backpressure: toggle out_ready every cycle and in_valid randomly during TX -> output byte sequence identical to the no-stall run; engine enables counted = 4 compute + 4 load.
- Abort in FCS after 2 FCS bytes -> next cycle IDLE, done=1, frame_ok=0, frame_err=1; a new TX frame after that produces a correct FCS.
- MAX_LEN=8, RX frame of 9 bytes -> 8 bytes forwarded, done with frame_err=1, frame_len=8. RX 4-byte frame with MIN_RX_LEN=5 -> frame_ok=0.
- Assert reset during DATA after 3 bytes -> next cycle busy=0, all crc_* outputs 0, frame_len=0; start ignored while reset=1.
